result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/find_pkg.sv | 24 ++
 rtl/result_reader.sv | 180 ++++++++++++++++++
 tb/tb_result_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/find_pkg.sv
// rtl/find_pkg.sv - shared frame states, header default and byte-count helpers for the result path
package find_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_E,
        S_CSUM
    } frame_state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    // Number of whole bytes needed to carry a sequence field of the given width
    function automatic int ns_bytes(input int seq_width);
        return (seq_width + 7) / 8;
    endfunction

    // Number of whole bytes needed to carry an energy field of the given width
    function automatic int ne_bytes(input int e_width);
        return (e_width + 7) / 8;
    endfunction

endpackage

// File: rtl/result_reader.sv
// rtl/result_reader.sv - captures the search result and streams it out as a checksummed byte frame
module result_reader
    import find_pkg::*;
#(
    parameter int         SEQ_WIDTH = 8,
    parameter int         E_WIDTH   = 20,
    parameter logic [7:0] HDR       = HDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEQ_WIDTH-1:0] i_seq,
    input  logic [E_WIDTH-1:0]   i_e,
    input  logic                 i_done,
    input  logic                 i_req,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int NS = ns_bytes(SEQ_WIDTH);
    localparam int NE = ne_bytes(E_WIDTH);

    frame_state_t         state_q;
    frame_state_t         state_d;

    logic                 done_q;
    logic                 capture;
    logic                 start;
    logic                 fire;
    logic                 pending_q;
    logic                 frame_done_q;
    logic                 cnt_last;

    logic [SEQ_WIDTH-1:0] seq_q;
    logic [E_WIDTH-1:0]   e_q;

    // The frame in flight is sent from these shadows so that a new capture
    // while busy can update seq_q/e_q without disturbing the bytes on the wire.
    logic [NS*8-1:0]      frame_seq;
    logic [NE*8-1:0]      frame_e;
    logic [NS*8-1:0]      seq_ext;
    logic [NE*8-1:0]      e_ext;

    logic [7:0]           byte_cnt;
    logic [7:0]           csum_q;
    logic [7:0]           seq_byte;
    logic [7:0]           e_byte;

    assign capture      = i_done & ~done_q;
    assign start        = (state_q == S_IDLE) & (capture | i_req | pending_q);
    assign fire         = o_valid & i_ready;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = frame_done_q;

    assign seq_byte = 8'(frame_seq >> {byte_cnt, 3'b000});
    assign e_byte   = 8'(frame_e >> {byte_cnt, 3'b000});

    // Zero-extend the frame source; on a capture cycle the fresh inputs win over the stale registers
    always_comb begin
        seq_ext                  = '0;
        e_ext                    = '0;
        seq_ext[SEQ_WIDTH-1:0]   = capture ? i_seq : seq_q;
        e_ext[E_WIDTH-1:0]       = capture ? i_e : e_q;
        cnt_last                 = (state_q == S_SEQ) ? (byte_cnt == 8'(NS - 1))
                                                      : (byte_cnt == 8'(NE - 1));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and stream outputs; every non-idle state offers exactly one byte
    always_comb begin
        state_d = state_q;
        o_valid = 1'b0;
        o_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                o_valid = 1'b1;
                o_data  = HDR;
                if (i_ready) state_d = S_SEQ;
            end
            S_SEQ: begin
                o_valid = 1'b1;
                o_data  = seq_byte;
                if (i_ready && cnt_last) state_d = S_E;
            end
            S_E: begin
                o_valid = 1'b1;
                o_data  = e_byte;
                if (i_ready && cnt_last) state_d = S_CSUM;
            end
            S_CSUM: begin
                o_valid = 1'b1;
                o_data  = csum_q;
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Rising-edge detect on i_done and capture of the result in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            seq_q  <= '0;
            e_q    <= '0;
        end else begin
            done_q <= i_done;
            if (capture) begin
                seq_q <= i_seq;
                e_q   <= i_e;
            end
        end
    end

    // One pending flag absorbs any number of captures made while a frame is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (start) begin
            pending_q <= 1'b0;
        end else if (capture && (state_q != S_IDLE)) begin
            pending_q <= 1'b1;
        end
    end

    // Snapshot the result to send when a frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_seq <= '0;
            frame_e   <= '0;
        end else if (start) begin
            frame_seq <= seq_ext;
            frame_e   <= e_ext;
        end
    end

    // Byte index within the sequence or energy field, wrapping at the end of each field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 8'h00;
        end else if (start) begin
            byte_cnt <= 8'h00;
        end else if (fire && ((state_q == S_SEQ) || (state_q == S_E))) begin
            byte_cnt <= cnt_last ? 8'h00 : byte_cnt + 8'h01;
        end
    end

    // Running XOR of the payload bytes as they are accepted; the header is not included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else if (start) begin
            csum_q <= 8'h00;
        end else if (fire && ((state_q == S_SEQ) || (state_q == S_E))) begin
            csum_q <= csum_q ^ o_data;
        end
    end

    // Completion pulse lands in the first idle cycle after the checksum byte is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= fire && (state_q == S_CSUM);
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - randomized and directed self-checking bench for result_reader
module tb_result_reader;

    typedef logic [7:0] bq_t[$];

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  i_seq   = 8'h00;
    logic [19:0] i_e     = 20'h0;
    logic        i_done  = 1'b0;
    logic        i_req   = 1'b0;
    logic        i_ready = 1'b1;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_frame_done;

    logic [11:0] w_seq   = 12'h000;
    logic [19:0] w_e     = 20'h0;
    logic        w_done  = 1'b0;
    logic        w_req   = 1'b0;
    logic        w_ready = 1'b1;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_busy;
    logic        w_fdone;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int cyc         = 0;
    int fdone_cnt   = 0;
    int w_fdone_cnt = 0;

    bq_t rx;
    bq_t wrx;
    bq_t mq;
    bq_t mf;
    int  rx_cyc[$];

    logic        m_pend   = 1'b0;
    logic        m_done_q = 1'b0;
    logic        m_fd     = 1'b0;
    logic [31:0] m_seq    = 32'h0;
    logic [31:0] m_e      = 32'h0;
    logic        exp_valid, m_fire, m_cap, m_nd;

    result_reader u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_seq        (i_seq),
        .i_e          (i_e),
        .i_done       (i_done),
        .i_req        (i_req),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    result_reader #(.SEQ_WIDTH(12), .E_WIDTH(20)) u_wide (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_seq        (w_seq),
        .i_e          (w_e),
        .i_done       (w_done),
        .i_req        (w_req),
        .o_data       (w_data),
        .o_valid      (w_valid),
        .i_ready      (w_ready),
        .o_busy       (w_busy),
        .o_frame_done (w_fdone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_bytes(input string name, input bq_t act, input bq_t exp);
        check({name, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < act.size()) check(name, 32'(act[i]), 32'(exp[i]));
    endtask

    // A whole frame from the rules: header, LSB-first payload fields, XOR of payload
    function automatic void make_frame(input int sw, input int ew, input logic [31:0] s,
                                       input logic [31:0] e, output bq_t f);
        logic [7:0]  cs;
        logic [31:0] sm, em;
        cs = 8'h00;
        sm = s & ((32'h1 << sw) - 32'h1);
        em = e & ((32'h1 << ew) - 32'h1);
        f  = {};
        f.push_back(8'hA5);
        for (int i = 0; i < (sw + 7) / 8; i++) begin
            f.push_back(8'(sm >> (8 * i)));
            cs = cs ^ 8'(sm >> (8 * i));
        end
        for (int i = 0; i < (ew + 7) / 8; i++) begin
            f.push_back(8'(em >> (8 * i)));
            cs = cs ^ 8'(em >> (8 * i));
        end
        f.push_back(cs);
    endfunction

    // Per-cycle comparison against the queue model, then advance the model across the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_busy", 32'(o_busy), 32'd0);
            check("rst_fdone", 32'(o_frame_done), 32'd0);
            check("rst_data", 32'(o_data), 32'd0);
            mq.delete();
            m_pend   = 1'b0;
            m_done_q = 1'b0;
            m_fd     = 1'b0;
            m_seq    = 32'h0;
            m_e      = 32'h0;
        end else begin
            exp_valid = (mq.size() != 0);
            check("valid", 32'(o_valid), 32'(exp_valid));
            check("busy", 32'(o_busy), 32'(exp_valid));
            check("frame_done", 32'(o_frame_done), 32'(m_fd));
            if (exp_valid) check("data", 32'(o_data), 32'(mq[0]));
            if (o_valid && i_ready) begin
                rx.push_back(o_data);
                rx_cyc.push_back(cyc);
            end
            if (o_frame_done) fdone_cnt++;
            m_fire = exp_valid && i_ready;
            m_cap  = i_done && !m_done_q;
            m_nd   = 1'b0;
            if (m_fire) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_nd = 1'b1;
            end
            if (!exp_valid) begin
                if (m_cap || i_req || m_pend) begin
                    make_frame(8, 20, m_cap ? 32'(i_seq) : m_seq, m_cap ? 32'(i_e) : m_e, mf);
                    mq     = mf;
                    m_pend = 1'b0;
                end
            end else if (m_cap) begin
                m_pend = 1'b1;
            end
            if (m_cap) begin
                m_seq = 32'(i_seq);
                m_e   = 32'(i_e);
            end
            m_done_q = i_done;
            m_fd     = m_nd;
        end
    end

    // Collector for the 12-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_valid && w_ready) wrx.push_back(w_data);
            if (w_fdone) w_fdone_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input string name);
        int b;
        b = 200;
        while (fdone_cnt < n && b > 0) begin
            step();
            b--;
        end
        check(name, 32'(fdone_cnt >= n), 32'd1);
    endtask

    task automatic clear_rx();
        rx.delete();
        rx_cyc.delete();
        fdone_cnt = 0;
    endtask

    bq_t exp_a, exp_b, exp_ab, exp_c, exp_w;

    initial begin
        exp_a  = '{8'hA5, 8'h1D, 8'h0C, 8'h00, 8'h00, 8'h11};
        exp_b  = '{8'hA5, 8'h2B, 8'h01, 8'h00, 8'h0F, 8'h25};
        exp_ab = '{8'hA5, 8'h1D, 8'h0C, 8'h00, 8'h00, 8'h11,
                   8'hA5, 8'h2B, 8'h01, 8'h00, 8'h0F, 8'h25};
        exp_c  = '{8'hA5, 8'h3C, 8'h05, 8'h00, 8'h00, 8'h39};
        exp_w  = '{8'hA5, 8'hBC, 8'h0A, 8'h45, 8'h23, 8'h01, 8'hD1};

        make_frame(8, 20, 32'h1D, 32'h0000C, mf);
        check_bytes("model_pin_a", mf, exp_a);
        make_frame(12, 20, 32'hABC, 32'h12345, mf);
        check_bytes("model_pin_w", mf, exp_w);

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Basic frame at full rate
        clear_rx();
        i_seq  = 8'h1D;
        i_e    = 20'h0000C;
        i_done = 1'b1;
        wait_frames(1, "frame_a_timeout");
        check_bytes("frame_a", rx, exp_a);
        if (rx_cyc.size() == 6) check("frame_a_back_to_back", 32'(rx_cyc[5] - rx_cyc[0]), 32'd5);

        // Back-pressure on the second energy byte
        i_done = 1'b0;
        repeat (2) step();
        clear_rx();
        i_done = 1'b1;
        begin
            int b;
            b = 40;
            while (rx.size() < 3 && b > 0) begin
                step();
                b--;
            end
            check("stall_reach", 32'(rx.size() >= 3), 32'd1);
        end
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_data", 32'(o_data), 32'h00);
            step();
        end
        i_ready = 1'b1;
        wait_frames(1, "frame_stall_timeout");
        check_bytes("frame_stall", rx, exp_a);

        // New capture while the header is held
        i_done = 1'b0;
        repeat (2) step();
        clear_rx();
        i_done = 1'b1;
        step();
        i_done  = 1'b0;
        i_ready = 1'b0;
        step();
        i_done = 1'b1;
        i_seq  = 8'h2B;
        i_e    = 20'hF0001;
        step();
        i_ready = 1'b1;
        wait_frames(2, "frame_ab_timeout");
        check_bytes("frame_ab", rx, exp_ab);

        // Retransmit request in idle, then a request while busy that must be ignored
        repeat (3) step();
        clear_rx();
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        repeat (2) step();
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        wait_frames(1, "frame_req_timeout");
        repeat (15) step();
        check_bytes("frame_req", rx, exp_b);
        check("req_busy_ignored", 32'(fdone_cnt), 32'd1);

        // Reset in the middle of a frame
        i_done = 1'b0;
        repeat (2) step();
        clear_rx();
        i_seq  = 8'h55;
        i_e    = 20'h12345;
        i_done = 1'b1;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        i_done = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("rst_abandon_len", 32'(rx.size()), 32'd1);
        if (rx.size() > 0) check("rst_abandon_hdr", 32'(rx[0]), 32'hA5);
        clear_rx();
        i_seq  = 8'h3C;
        i_e    = 20'h00005;
        i_done = 1'b1;
        wait_frames(1, "frame_c_timeout");
        check_bytes("frame_c", rx, exp_c);

        // i_done already high when reset releases counts as a capture
        repeat (3) step();
        rst_n = 1'b0;
        step();
        clear_rx();
        rst_n = 1'b1;
        wait_frames(1, "frame_rel_timeout");
        check_bytes("frame_rel", rx, exp_c);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            i_ready = ($urandom_range(0, 3) != 0);
            i_req   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) i_done = ~i_done;
            i_seq = 8'($urandom);
            i_e   = 20'($urandom);
        end
        step();
        rst_n   = 1'b1;
        i_ready = 1'b1;
        i_req   = 1'b0;
        repeat (40) step();

        // 12-bit sequence instance
        wrx.delete();
        w_fdone_cnt = 0;
        w_seq  = 12'hABC;
        w_e    = 20'h12345;
        w_done = 1'b1;
        begin
            int b;
            b = 40;
            while (wrx.size() < 7 && b > 0) begin
                step();
                b--;
            end
        end
        repeat (3) step();
        check_bytes("frame_wide", wrx, exp_w);
        check("wide_fdone", 32'(w_fdone_cnt), 32'd1);
        check("wide_idle", 32'(w_busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
